// File: rtl/race_start_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : race_start_sequencer_if
// Brief    : Button inputs and lamp/display outputs of the start sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface race_start_sequencer_if #(
    parameter int NUM_LIGHTS = 5
);
    logic                  start;
    logic                  driver_btn;
    logic                  abort;
    logic [NUM_LIGHTS-1:0] lights;
    logic                  go;
    logic                  busy;
    logic                  false_start;
    logic                  done;
    logic [15:0]           reaction_ms;

    // Board side: drives the buttons, observes the panel
    modport master (
        output start, driver_btn, abort,
        input  lights, go, busy, false_start, done, reaction_ms
    );

    // Sequencer side
    modport slave (
        input  start, driver_btn, abort,
        output lights, go, busy, false_start, done, reaction_ms
    );
endinterface
`default_nettype wire

// File: rtl/race_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : race_start_sequencer
// Brief    : Start-lights sequencer with random hold, reaction timer and
//            false-start detection. Tick and ms rates are clock enables.
// Revision : 1.0 - initial release
// ============================================================================
module race_start_sequencer #(
    parameter int         TICK_DIV     = 25_000_000,
    parameter int         REACT_DIV    = 50_000,
    parameter int         NUM_LIGHTS   = 5,
    parameter int         HOLD_MIN     = 2,
    parameter int         HOLD_RANGE_W = 2,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input logic                   clk_in,
    input logic                   Reset,
    race_start_sequencer_if.slave bus
);
    localparam int c_HOLD_W = HOLD_RANGE_W + $clog2(HOLD_MIN + 1) + 1;
    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_MS_W   = (REACT_DIV > 1) ? $clog2(REACT_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_MS_W-1:0]   c_MS_LAST   = c_MS_W'(REACT_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_HOLD   = 3'd2,
        S_GO     = 3'd3,
        S_RESULT = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_LIGHTS-1:0] r_lights, w_lights_nxt;
    logic                  r_go, w_go_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_false_start, w_fs_nxt;
    logic                  r_done, w_done_nxt;
    logic [15:0]           r_reaction, w_reaction_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [c_TICK_W-1:0]   r_tick_cnt, w_tick_nxt;
    logic [c_MS_W-1:0]     r_ms_cnt, w_ms_nxt;
    logic [7:0]            r_lfsr;
    logic                  w_tick;

    // Tick only exists while the lamps are being sequenced
    assign w_tick = ((r_state == S_ARM) || (r_state == S_HOLD)) && (r_tick_cnt == c_TICK_LAST);

    // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    // State and registered outputs
    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_lights      <= '0;
            r_go          <= 1'b0;
            r_busy        <= 1'b0;
            r_false_start <= 1'b0;
            r_done        <= 1'b0;
            r_reaction    <= '0;
            r_hold_cnt    <= '0;
            r_tick_cnt    <= '0;
            r_ms_cnt      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_lights      <= w_lights_nxt;
            r_go          <= w_go_nxt;
            r_busy        <= w_busy_nxt;
            r_false_start <= w_fs_nxt;
            r_done        <= w_done_nxt;
            r_reaction    <= w_reaction_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_tick_cnt    <= w_tick_nxt;
            r_ms_cnt      <= w_ms_nxt;
        end
    end

    // Next state and next outputs; priority abort > driver_btn > tick/ms
    always_comb begin
        w_state_nxt    = r_state;
        w_lights_nxt   = r_lights;
        w_go_nxt       = r_go;
        w_fs_nxt       = r_false_start;
        w_done_nxt     = 1'b0;
        w_reaction_nxt = r_reaction;
        w_hold_nxt     = r_hold_cnt;
        w_tick_nxt     = r_tick_cnt;
        w_ms_nxt       = r_ms_cnt;

        if (bus.abort) begin
            w_state_nxt    = S_IDLE;
            w_lights_nxt   = '0;
            w_go_nxt       = 1'b0;
            w_fs_nxt       = 1'b0;
            w_reaction_nxt = '0;
            w_hold_nxt     = '0;
            w_tick_nxt     = '0;
            w_ms_nxt       = '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_RESULT, S_FAULT: begin
                    if (bus.start) begin
                        w_state_nxt    = S_ARM;
                        w_lights_nxt   = '0;
                        w_go_nxt       = 1'b0;
                        w_fs_nxt       = 1'b0;
                        w_reaction_nxt = '0;
                        w_tick_nxt     = '0;
                    end
                end
                S_ARM, S_HOLD: begin
                    if (bus.driver_btn) begin
                        // False start beats any coincident tick
                        w_state_nxt    = S_FAULT;
                        w_lights_nxt   = '0;
                        w_fs_nxt       = 1'b1;
                        w_done_nxt     = 1'b1;
                        w_reaction_nxt = '0;
                        w_tick_nxt     = '0;
                    end else begin
                        w_tick_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
                        if (w_tick && (r_state == S_ARM)) begin
                            w_lights_nxt = {r_lights[NUM_LIGHTS-2:0], 1'b1};
                            // Last lamp lit: draw the random hold length now
                            if (&r_lights[NUM_LIGHTS-2:0]) begin
                                w_state_nxt = S_HOLD;
                                w_hold_nxt  = c_HOLD_W'(HOLD_MIN) +
                                              c_HOLD_W'(r_lfsr[HOLD_RANGE_W-1:0]);
                            end
                        end else if (w_tick) begin
                            if (r_hold_cnt == c_HOLD_ONE) begin
                                w_state_nxt    = S_GO;
                                w_lights_nxt   = '0;
                                w_go_nxt       = 1'b1;
                                w_ms_nxt       = '0;
                                w_reaction_nxt = '0;
                                w_tick_nxt     = '0;
                            end else begin
                                w_hold_nxt = r_hold_cnt - 1'b1;
                            end
                        end
                    end
                end
                S_GO: begin
                    if (bus.driver_btn) begin
                        // Period in progress at the press is not counted
                        w_state_nxt = S_RESULT;
                        w_go_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_ms_nxt    = '0;
                    end else if (r_ms_cnt == c_MS_LAST) begin
                        w_ms_nxt = '0;
                        if (r_reaction != 16'hFFFF) w_reaction_nxt = r_reaction + 16'd1;
                    end else begin
                        w_ms_nxt = r_ms_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_HOLD) || (w_state_nxt == S_GO);
    end

    assign bus.lights      = r_lights;
    assign bus.go          = r_go;
    assign bus.busy        = r_busy;
    assign bus.false_start = r_false_start;
    assign bus.done        = r_done;
    assign bus.reaction_ms = r_reaction;
endmodule
`default_nettype wire

// File: tb/tb_race_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_race_start_sequencer
// Brief    : Directed bench; expected panel states queued, then popped and
//            compared against the outputs one cycle-accurate step at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_race_start_sequencer;
    localparam logic [7:0] c_SEED = 8'hA5;

    logic clk_in = 1'b0;
    logic Reset;

    race_start_sequencer_if #(.NUM_LIGHTS(5)) bus1 ();
    race_start_sequencer_if #(.NUM_LIGHTS(5)) bus2 ();

    race_start_sequencer #(
        .TICK_DIV(4), .REACT_DIV(2), .NUM_LIGHTS(5),
        .HOLD_MIN(2), .HOLD_RANGE_W(2), .LFSR_SEED(c_SEED)
    ) dut (
        .clk_in(clk_in), .Reset(Reset), .bus(bus1)
    );

    race_start_sequencer #(
        .TICK_DIV(4), .REACT_DIV(1), .NUM_LIGHTS(5),
        .HOLD_MIN(2), .HOLD_RANGE_W(2), .LFSR_SEED(c_SEED)
    ) dut_sat (
        .clk_in(clk_in), .Reset(Reset), .bus(bus2)
    );

    always #5 clk_in = ~clk_in;

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, running every cycle
    logic [7:0] m_lfsr;
    always @(posedge clk_in or posedge Reset) begin
        if (Reset) m_lfsr <= c_SEED;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        string       tag;
        logic [24:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   h;

    // Output vector layout: {lights, go, busy, false_start, done, reaction_ms}
    function automatic logic [24:0] mk(input logic [4:0] l, input logic g, input logic b,
                                       input logic fs, input logic d, input logic [15:0] r);
        return {l, g, b, fs, d, r};
    endfunction

    function automatic logic [24:0] obs1();
        return {bus1.lights, bus1.go, bus1.busy, bus1.false_start, bus1.done, bus1.reaction_ms};
    endfunction

    function automatic logic [24:0] obs2();
        return {bus2.lights, bus2.go, bus2.busy, bus2.false_start, bus2.done, bus2.reaction_ms};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic expect_push(input string tag, input logic [24:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [24:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Start pulse sampled at the next edge; returns just after that edge (cycle 0)
    task automatic start1();
        bus1.start = 1'b1;
        step(1);
        bus1.start = 1'b0;
    endtask

    task automatic start2();
        bus2.start = 1'b1;
        step(1);
        bus2.start = 1'b0;
    endtask

    initial begin
        bus1.start = 1'b0; bus1.driver_btn = 1'b0; bus1.abort = 1'b0;
        bus2.start = 1'b0; bus2.driver_btn = 1'b0; bus2.abort = 1'b0;
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
        step(1);
        expect_push("reset_state", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());
        expect_push("reset_state_sat", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs2());

        // Asynchronous reset in the middle of HOLD
        start1();
        step(20);
        expect_push("t1_hold_lamps", mk(5'h1F, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        #2 Reset = 1'b1;
        #1;
        expect_push("t1_async_reset", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());
        step(1);
        Reset = 1'b0;
        step(1);
        expect_push("t1_idle_after_reset", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());

        // Lamp sequence and random hold
        start1();
        step(3);
        expect_push("t2_no_lamp_c3", mk(5'h00, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t2_lamp1_c4", mk(5'h01, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(4);
        expect_push("t2_lamp2_c8", mk(5'h03, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(11);
        h = 2 + int'(m_lfsr[1:0]);
        step(1);
        expect_push("t2_all_on_c20", mk(5'h1F, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(4 * h - 1);
        expect_push("t2_hold_before_go", mk(5'h1F, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t2_go_rise", mk(5'h00, 1, 1, 0, 0, 16'd0));
        check_pop(obs1());

        // Reaction measured, button sampled 7 cycles after go
        step(6);
        expect_push("t3_count_before_btn", mk(5'h00, 1, 1, 0, 0, 16'd3));
        check_pop(obs1());
        bus1.driver_btn = 1'b1;
        step(1);
        bus1.driver_btn = 1'b0;
        expect_push("t3_result", mk(5'h00, 0, 0, 0, 1, 16'd3));
        check_pop(obs1());
        step(1);
        expect_push("t3_done_one_cycle", mk(5'h00, 0, 0, 0, 0, 16'd3));
        check_pop(obs1());
        start1();
        expect_push("t3_restart_clears", mk(5'h00, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());

        // False start with two lamps lit (button sampled at cycle 10)
        step(9);
        expect_push("t4_two_lamps", mk(5'h03, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        bus1.driver_btn = 1'b1;
        step(1);
        bus1.driver_btn = 1'b0;
        expect_push("t4_false_start", mk(5'h00, 0, 0, 1, 1, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t4_fault_hold", mk(5'h00, 0, 0, 1, 0, 16'd0));
        check_pop(obs1());

        // False start coincident with the final hold tick
        start1();
        expect_push("t4_restart_clears_fs", mk(5'h00, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(19);
        h = 2 + int'(m_lfsr[1:0]);
        step(1);
        step(4 * h - 1);
        expect_push("t4_last_hold_cycle", mk(5'h1F, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        bus1.driver_btn = 1'b1;
        step(1);
        bus1.driver_btn = 1'b0;
        expect_push("t4_fault_on_final_tick", mk(5'h00, 0, 0, 1, 1, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t4_no_go_after_fault", mk(5'h00, 0, 0, 1, 0, 16'd0));
        check_pop(obs1());

        // Start while busy is ignored; abort from HOLD
        start1();
        step(1);
        bus1.start = 1'b1;
        step(1);
        bus1.start = 1'b0;
        step(1);
        expect_push("t5_busy_start_c3", mk(5'h00, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t5_busy_start_c4", mk(5'h01, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        step(17);
        expect_push("t5_in_hold", mk(5'h1F, 0, 1, 0, 0, 16'd0));
        check_pop(obs1());
        bus1.abort = 1'b1;
        step(1);
        bus1.abort = 1'b0;
        expect_push("t5_abort_idle", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());
        step(1);
        expect_push("t5_abort_stays_idle", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());

        // Saturation with REACT_DIV=1
        start2();
        step(19);
        h = 2 + int'(m_lfsr[1:0]);
        step(1);
        step(4 * h);
        expect_push("t6_go_rise", mk(5'h00, 1, 1, 0, 0, 16'd0));
        check_pop(obs2());
        step(65534);
        expect_push("t6_count_fffe", mk(5'h00, 1, 1, 0, 0, 16'hFFFE));
        check_pop(obs2());
        step(1);
        expect_push("t6_count_ffff", mk(5'h00, 1, 1, 0, 0, 16'hFFFF));
        check_pop(obs2());
        step(4465);
        expect_push("t6_saturated_hold", mk(5'h00, 1, 1, 0, 0, 16'hFFFF));
        check_pop(obs2());
        bus2.driver_btn = 1'b1;
        step(1);
        bus2.driver_btn = 1'b0;
        expect_push("t6_result_frozen", mk(5'h00, 0, 0, 0, 1, 16'hFFFF));
        check_pop(obs2());
        expect_push("t6_other_dut_idle", mk(5'h00, 0, 0, 0, 0, 16'd0));
        check_pop(obs1());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/race_start_sequencer.md
Name: race_start_sequencer

Overview:
Sequences the race start-lights panel: lights NUM_LIGHTS lamps one per tick, holds for a pseudo-random number of ticks, then extinguishes all lamps and asserts GO. It measures driver reaction time in ms and flags false starts. The block generates internal tick and ms enables from the 50 MHz clock; it drives no derived clocks. It sits between the board buttons (already synchronised/debounced) and the lamp/seven-segment drivers.

Parameters:
TICK_DIV, 25_000_000, clk_in cycles per light tick (0.5 s at 50 MHz); >=2
REACT_DIV, 50_000, clk_in cycles per reaction count unit (1 ms); >=1
NUM_LIGHTS, 5, number of start lamps; >=2
HOLD_MIN, 2, minimum hold ticks after the last lamp; >=1
HOLD_RANGE_W, 2, random extra hold = 0..2^HOLD_RANGE_W-1 ticks
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk_in  input  1  50 MHz clock
Reset  input  1  asynchronous active-high reset
start  input  1  begin run; sampled only in IDLE, RESULT and FAULT
driver_btn  input  1  driver reaction button, synchronous level
abort  input  1  synchronous return to IDLE from any state
lights  output  NUM_LIGHTS  lamp drives; bit0 lights first
go  output  1  high while in GO
busy  output  1  high in ARM, HOLD and GO
false_start  output  1  sticky; set on button press in ARM/HOLD
done  output  1  one-cycle pulse on entry to RESULT or FAULT
reaction_ms  output  16  reaction count, saturating

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0. Tick and ms prescalers 0. hold_cnt 0. LFSR=LFSR_SEED. Reset mid-run aborts immediately, with no done pulse.
- All outputs are registered. Event priority within a cycle: abort > driver_btn > tick/ms.
- Tick: the prescaler counts 0..TICK_DIV-1 only in ARM and HOLD. tick is a 1-cycle internal pulse when the count is TICK_DIV-1, and the count then wraps to 0. The prescaler is cleared on entering ARM, so the first tick occurs TICK_DIV cycles after the start sample.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk_in cycle in all states.
- States and transitions:
  - IDLE: start=1 -> ARM. On entry to ARM: lights=0, false_start=0, reaction_ms=0.
  - ARM: on each tick, lights <= {lights[N-2:0],1}. On the tick that makes lights all ones -> HOLD, with hold_cnt = HOLD_MIN + LFSR[HOLD_RANGE_W-1:0], sampled in that cycle.
  - HOLD: lights stay all ones. Each tick decrements hold_cnt. On a tick with hold_cnt==1 -> GO: lights=0, go=1, ms prescaler=0, reaction_ms=0.
  - ARM/HOLD with driver_btn=1 -> FAULT: lights=0, false_start=1, done=1 for one cycle, reaction_ms=0. This wins over a coincident tick, including the final HOLD tick.
  - GO: the ms prescaler counts 0..REACT_DIV-1. On wrap, reaction_ms increments, saturating at 16'hFFFF. There is no timeout. driver_btn=1 -> RESULT: go=0, done=1 for one cycle, reaction_ms frozen. The count increments only for periods fully elapsed before the button cycle.
  - RESULT/FAULT: outputs hold. start=1 -> ARM (new run).
- start while busy is ignored. driver_btn in IDLE/RESULT/FAULT is ignored. A button held across GO entry is recorded as a reaction in the first GO cycle (reaction_ms=0).
- abort=1, any state -> IDLE next cycle: lights, go, busy, false_start and reaction_ms cleared; prescalers cleared; no done pulse.
- hold_cnt width = HOLD_RANGE_W+$clog2(HOLD_MIN+1)+1. Prescaler widths use $clog2 of their divisor.

Test Plan:
Bench parameters: TICK_DIV=4, REACT_DIV=2, NUM_LIGHTS=5, HOLD_MIN=2, HOLD_RANGE_W=2.

1. Reset asserted mid-HOLD -> all outputs 0 immediately. After release, state=IDLE and busy=0.
2. start pulse at cycle 0 -> lights=00001 at cycle 4, 00011 at 8, then 11111 at 20. go rises (HOLD_MIN+r)*4 cycles later, where r is taken from a reference LFSR model (r=0..3). lights=0 in the same cycle go rises.
3. driver_btn asserted 7 cycles after go rises -> reaction_ms=3, go=0, done high exactly 1 cycle, busy=0. start then begins a new run and clears reaction_ms.
4. driver_btn at cycle 10 (2 lamps lit) -> lights=0, false_start=1, done 1-cycle pulse, reaction_ms=0. Repeat with the button coincident with the final HOLD tick -> FAULT, go never asserted.
5. abort during HOLD -> IDLE next cycle with lights=0. A start pulse during ARM has no effect on lamp timing.
6. REACT_DIV=1, no button for 70,000 cycles in GO -> reaction_ms saturates at 16'hFFFF and holds.
